// File: rtl/matmul_engine.sv
// Square unsigned matrix multiplier: holds A, B and C internally, computes C = A*B
// one element at a time (clear, DIM multiply-accumulates, write) on start/done.
module matmul_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  load_sel,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [3:0]            shift_amt,
    input  logic                  sat_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int N_ELEM = DIM * DIM;
    localparam logic [ADDR_WIDTH:0]   N_ELEM_A = (ADDR_WIDTH + 1)'(N_ELEM);
    localparam logic [ADDR_WIDTH-1:0] DIM_A    = ADDR_WIDTH'(DIM);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DIM - 1);

    // Handshake: start is a level sampled only in IDLE; busy is high from the cycle
    // after start up to and including the single done cycle. rd_valid pulses one
    // cycle after each rd_en accepted while not busy.
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_WRITE, S_DONE} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH-1:0] a_mem [N_ELEM];
    logic [DATA_WIDTH-1:0] b_mem [N_ELEM];
    logic [ACC_WIDTH-1:0]  c_mem [N_ELEM];

    logic [IDX_W-1:0]        i_cnt, j_cnt, k_cnt, k_rd;
    logic [ACC_WIDTH-1:0]    acc;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ADDR_WIDTH-1:0]   a_addr, b_addr, c_addr;
    logic                    last_elem;
    logic [ACC_WIDTH-1:0]    rd_word, rd_stage;
    logic [DATA_WIDTH-1:0]   rd_narrow;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: state_next = S_MAC;
            S_MAC:   if (k_cnt == LAST_IDX) state_next = S_WRITE;
            S_WRITE: state_next = last_elem ? S_DONE : S_CLEAR;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Operand index issued this cycle; its data is consumed by the next MAC cycle.
    always_comb begin
        k_rd = '0;
        if (state == S_MAC && k_cnt != LAST_IDX) k_rd = k_cnt + IDX_W'(1);
    end

    assign a_addr    = ADDR_WIDTH'(i_cnt) * DIM_A + ADDR_WIDTH'(k_rd);
    assign b_addr    = ADDR_WIDTH'(k_rd) * DIM_A + ADDR_WIDTH'(j_cnt);
    assign c_addr    = ADDR_WIDTH'(i_cnt) * DIM_A + ADDR_WIDTH'(j_cnt);
    assign last_elem = (i_cnt == LAST_IDX) && (j_cnt == LAST_IDX);
    assign prod      = a_q * b_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    acc   <= '0;
                    k_cnt <= '0;
                    a_q   <= a_mem[a_addr];
                    b_q   <= b_mem[b_addr];
                end
                S_MAC: begin
                    acc   <= acc + ACC_WIDTH'(prod);
                    k_cnt <= k_cnt + IDX_W'(1);
                    a_q   <= a_mem[a_addr];
                    b_q   <= b_mem[b_addr];
                end
                S_WRITE: begin
                    if (!last_elem) begin
                        if (j_cnt == LAST_IDX) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + IDX_W'(1);
                        end else begin
                            j_cnt <= j_cnt + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; C keeps any entries written before a mid-run reset.
    always_ff @(posedge clk) begin
        if (load_en && !busy && ({1'b0, load_addr} < N_ELEM_A)) begin
            if (load_sel) b_mem[load_addr] <= load_data;
            else          a_mem[load_addr] <= load_data;
        end
        if (state == S_WRITE) c_mem[c_addr] <= acc;
    end

    always_comb begin
        rd_word   = ({1'b0, rd_addr} < N_ELEM_A) ? c_mem[rd_addr] : '0;
        rd_stage  = rd_word >> shift_amt;
        rd_narrow = rd_stage[DATA_WIDTH-1:0];
        if (sat_en && (|(rd_stage >> DATA_WIDTH))) rd_narrow = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en && !busy;
            if (rd_en && !busy) rd_data <= rd_narrow;
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: identity, max-value narrowing, latency,
// busy protection, mid-run reset and out-of-range access.
module tb_matmul_engine;

    localparam int DW = 8, DIM = 4, AW = 6, ACCW = 18, N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0, load_sel = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [3:0]    shift_amt = '0;
    logic          sat_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int a_m [N];
    int b_m [N];

    matmul_engine #(.DATA_WIDTH(DW), .DIM(DIM), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .shift_amt(shift_amt), .sat_en(sat_en),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit sel, input int addr, input int data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = addr[AW-1:0];
        load_data = data[DW-1:0];
        tick();
        load_en = 1'b0;
        if (addr < N) begin
            if (sel) b_m[addr] = data;
            else     a_m[addr] = data;
        end
    endtask

    function automatic int exp_c(input int idx);
        int s = 0;
        for (int k = 0; k < DIM; k++)
            s += a_m[(idx / DIM) * DIM + k] * b_m[k * DIM + (idx % DIM)];
        return s % (1 << ACCW);
    endfunction

    function automatic int narrow(input int c, input int sh, input int sat);
        int st = c >> sh;
        if (sat != 0) return (st > 255) ? 255 : st;
        return st & 255;
    endfunction

    task automatic read_one(input int addr, input int sh, input int sat, input int exp);
        rd_en     = 1'b1;
        rd_addr   = addr[AW-1:0];
        shift_amt = sh[3:0];
        sat_en    = sat[0];
        tick();
        rd_en = 1'b0;
        check($sformatf("rd_valid a%0d", addr), rd_valid, 1);
        check($sformatf("rd_data a%0d s%0d t%0d", addr, sh, sat), rd_data, exp);
    endtask

    // Start at edge 0 (any load already set up rides along), then watch busy/done
    // each cycle; optionally poke start/load/read at cycle inject or reset at rst_at.
    task automatic run(input int inject, input int rst_at);
        start = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        for (int c = 1; c <= 97; c++) begin
            check($sformatf("busy c%0d", c), busy, 1);
            check($sformatf("done c%0d", c), done, (c == 97));
            if (c == rst_at) begin
                rst = 1'b0;
                tick();
                check("rst busy", busy, 0);
                check("rst done", done, 0);
                check("rst rd_valid", rd_valid, 0);
                rst = 1'b1;
                return;
            end
            if (inject > 0 && c == inject + 1) begin
                check("busy rd_valid", rd_valid, 0);
                start   = 1'b0;
                load_en = 1'b0;
                rd_en   = 1'b0;
            end
            if (inject > 0 && c == inject) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_sel  = 1'b0;
                load_addr = '0;
                load_data = '0;
                rd_en     = 1'b1;
                rd_addr   = '0;
            end
            tick();
        end
        check("busy c98", busy, 0);
        check("done c98", done, 0);
    endtask

    initial begin
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        rst = 1'b1;
        tick();

        // Identity; last B element is written in the same cycle as start.
        for (int n = 0; n < N; n++) load(1'b0, n, (n / DIM == n % DIM) ? 1 : 0);
        for (int n = 0; n < N - 1; n++) load(1'b1, n, n + 1);
        load_en = 1'b1; load_sel = 1'b1; load_addr = 6'd15; load_data = 8'd16;
        b_m[15] = 16;
        run(0, 0);
        rd_en = 1'b1; shift_amt = '0; sat_en = 1'b0;
        for (int n = 0; n < N; n++) begin
            rd_addr = n[AW-1:0];
            tick();
            check($sformatf("ident valid %0d", n), rd_valid, 1);
            check($sformatf("ident data %0d", n), rd_data, n + 1);
        end
        rd_en = 1'b0;
        tick();
        check("rd_valid pulse", rd_valid, 0);
        check("rd_data hold", rd_data, 16);

        // All-255 operands, out-of-range loads, busy-time poke at cycle 20.
        for (int n = 0; n < N; n++) load(1'b0, n, 255);
        for (int n = 0; n < N; n++) load(1'b1, n, 255);
        load(1'b0, 16, 7);
        load(1'b1, 16, 7);
        read_one(16, 0, 0, 0);
        run(20, 0);
        for (int n = 0; n < N; n++) read_one(n, 0, 0, 8'h04);
        read_one(0, 0, 1, 255);
        read_one(5, 10, 0, 254);
        read_one(15, 2, 1, 255);
        read_one(63, 0, 1, 0);

        // Mixed pattern: reset at cycle 40, then a clean full run.
        for (int n = 0; n < N; n++) load(1'b0, n, n + 1);
        for (int n = 0; n < N; n++) load(1'b1, n, 2 * n + 3);
        run(0, 40);
        run(0, 0);
        read_one(0, 0, 0, 190);
        for (int n = 0; n < N; n++)
            read_one(n, (n * 3) % 12, n % 2, narrow(exp_c(n), (n * 3) % 12, n % 2));

        // Back-to-back start right after completion.
        run(0, 0);
        read_one(10, 0, 1, narrow(exp_c(10), 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Self-contained, parametrised square-matrix multiplier with its own controller. It holds operand matrices A and B and result matrix C in internal storage and computes C = A·B on a start/done handshake. It returns C entries through a read port with a selectable right-shift and a truncate or saturate output mode. It is the successor to the fixed 8-bit, externally-sequenced multiply datapath and replaces that datapath together with its external control.

## Interface
- DATA_WIDTH, 8, operand element width (unsigned)
- DIM, 4, matrix dimension (DIM×DIM)
- ADDR_WIDTH, 6, element address width; DIM*DIM ≤ 2^ADDR_WIDTH required
- ACC_WIDTH, 18, accumulator/C element width; ≥ 2*DATA_WIDTH + clog2(DIM) for overflow-free results

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- load_en  in  1  write one operand element this cycle
- load_sel  in  1  0 = A, 1 = B
- load_addr  in  ADDR_WIDTH  row-major address i*DIM+j
- load_data  in  DATA_WIDTH  element value
- start  in  1  begin computation (sampled in IDLE only)
- busy  out  1  computation in progress
- done  out  1  one-cycle completion pulse
- rd_en  in  1  read one C element
- rd_addr  in  ADDR_WIDTH  row-major C address
- shift_amt  in  4  right shift applied to C element before narrowing
- sat_en  in  1  0 = truncate to low DATA_WIDTH bits, 1 = saturate to 2^DATA_WIDTH−1
- rd_data  out  DATA_WIDTH  narrowed C element
- rd_valid  out  1  rd_data valid

## Operation
- Arithmetic is unsigned. C[i][j] = Σk A[i][k]*B[k][j], accumulated in ACC_WIDTH bits. If ACC_WIDTH is undersized, the result wraps modulo 2^ACC_WIDTH with no flag.
- All storage uses synchronous write. A, B and C are not cleared by reset.
- Loads are accepted only when busy=0. load_en while busy=1 is ignored. Writes with addr ≥ DIM*DIM are ignored.
- FSM states: IDLE, CLEAR, MAC, WRITE, DONE.
  - IDLE: start=1 → CLEAR with i=j=0.
  - CLEAR (1 cycle): acc←0; issue A[i][0] and B[0][j] reads.
  - MAC (DIM cycles): acc←acc + product of the data read in the previous cycle; issue the next k.
  - WRITE (1 cycle): C[i][j]←acc. If (i,j) is the last element → DONE. Otherwise advance j, then i, and go to CLEAR.
  - DONE (1 cycle): done=1 → IDLE.
- start in any state other than IDLE is ignored.
- load_en and start in the same IDLE cycle: the write completes, and the computation uses the new value.
- Read path: stage = C[rd_addr] >> shift_amt.
  - sat_en=0: rd_data = stage[DATA_WIDTH-1:0].
  - sat_en=1: rd_data = min(stage, 2^DATA_WIDTH−1).
  - rd_addr ≥ DIM*DIM returns rd_data=0 with rd_valid=1.
  - rd_en while busy=1 is ignored: rd_valid=0 next cycle.

## Timing
- Reset values: busy=0, done=0, rd_valid=0, rd_data=0, FSM=IDLE, acc=0, i=j=k=0.
- Reset mid-computation: on the next edge, all state returns to reset values. Any C entries already written keep their values.
- The per-element cost is DIM+2 cycles.
- Count the edge that samples start as edge 0. busy=1 in cycles 1 through DIM*DIM*(DIM+2)+1 inclusive. done=1 only in the last of those cycles. For DIM=4 this is cycle 97.
- A new start is accepted in the cycle after done, once the FSM is back in IDLE.
- Read latency is 1 cycle: rd_en sampled at edge n gives rd_valid/rd_data in cycle n+1. rd_valid is a single-cycle pulse per rd_en. rd_data holds its value when rd_valid=0.
- Back-to-back reads are supported at one per cycle.

## Test plan
- Identity: A=I, B[n]=n+1 for n=0..15, start. Then read all 16 entries with shift 0, sat 0 → rd_data = 1..16 in order, one cycle after each rd_en.
- Max values: A=B=all 255. Expected C entries = 260100 (0x3F804).
  - shift 0, sat 0 → 0x04
  - shift 0, sat 1 → 255
  - shift 10, sat 0 → 254
- Latency: start pulse at edge 0 → busy=1 for cycles 1–97, done=1 in cycle 97 only, busy=0 in cycle 98.
- Busy protection:
  - start at cycle 20 → no restart, done still at cycle 97.
  - load_en to A[0] at cycle 20 → A unchanged, and the computed C matches the pre-load A.
  - rd_en at cycle 20 → rd_valid=0.
- Reset mid-run: rst=0 at cycle 40 → next cycle busy=0, done=0, rd_valid=0. A new start then gives the correct full result with done 97 cycles later.
- Out-of-range access: load_en at address 16 is ignored. rd_addr=16 → rd_valid=1, rd_data=0.
